// File: rtl/fairy_sram_arbiter.sv
// -----------------------------------------------------------------------------
// fairy_sram_arbiter
//
// Purpose:
//   N-channel front end for a single SRAM port. Channels post read/write
//   requests. The arbiter picks one winner at a time and presents it to the
//   SRAM until sram_ack. It also tracks outstanding reads with an in-order tag
//   FIFO, so each returned read beat goes back to the channel that issued it.
//
// Optional build macro:
//   FAIRY_ARB_FIXED_PRIO_EN - defined: fixed priority, lowest channel index
//                             wins (no RR pointer). Undefined: round-robin.
//
// Ports:
//   aclk, areset_n   clock, asynchronous active-low reset
//   ch_req/ch_wr     per-channel request and direction (1 = write)
//   ch_be            packed byte enables, DATA_W/8 bits per channel
//   ch_addr/ch_wdata packed address / write data, one slice per channel
//   ch_gnt           one-cycle pulse when the SRAM accepted that channel
//   ch_rvalid        one-cycle pulse when read data for that channel is valid
//   ch_rdata         shared read data; holds its value between pulses
//   sram_cen         active-low byte chip enables (all 1s = idle)
//   sram_wr/addr/wdata  request presented to the SRAM
//   sram_ack         SRAM accepted the presented request
//   sram_rrdy/rdata  in-order read data return
//   err_o            sticky: read data returned with no read outstanding
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | request stage empty, arbitrating among eligible channels
// ISSUE | request stage presented on sram_*, waiting for sram_ack
// -----------------------------------------------------------------------------
module fairy_sram_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_be,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic [DATA_W/8-1:0]          sram_cen,
  output logic                         sram_wr,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_wdata,
  input  logic                         sram_ack,
  input  logic                         sram_rrdy,
  input  logic [DATA_W-1:0]            sram_rdata,
  output logic                         err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CR_W  = PTR_W + 1;
  localparam logic [CR_W-1:0] CR_MAX  = CR_W'(OUTSTANDING);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CR_W-1:0]   credits;
  logic [CH_W-1:0]   req_ch;
  logic              req_wr;
  logic [BE_W-1:0]   req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic [CH_W-1:0]   tag_mem [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CR_W-1:0]   fifo_cnt;
  logic [CH_W-1:0]   pop_tag;

  logic              found;
  logic [CH_W-1:0]   win;
  logic              latch, accept, push, pop, cr_inc;
  logic [NUM_CH-1:0] gnt_nxt, rvalid_nxt;

`ifndef FAIRY_ARB_FIXED_PRIO_EN
  logic [CH_W-1:0]   rr_ptr;
`endif

  // Arbitration: first eligible channel, scanning from the RR pointer
  // (or from channel 0 in fixed-priority builds). Reads need a free credit.
  always_comb begin
    logic [CH_W-1:0] idx;
    int              sum;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef FAIRY_ARB_FIXED_PRIO_EN
      sum = i;
`else
      sum = int'(rr_ptr) + i;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
`endif
      idx = CH_W'(sum);
      if (!found && ch_req[idx] && (ch_wr[idx] || (credits < CR_MAX))) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign latch   = (state == IDLE) && found;
  assign accept  = (state == ISSUE) && sram_ack;
  assign push    = accept && !req_wr;
  assign pop     = sram_rrdy && (fifo_cnt != '0);
  assign cr_inc  = latch && !ch_wr[win];
  assign pop_tag = tag_mem[rd_ptr];

  // State register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)    state_nxt = ISSUE;
      ISSUE:   if (sram_ack) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // SRAM-side outputs; chip enables only assert while a request is presented
  always_comb begin
    sram_cen   = '1;
    if (state == ISSUE) sram_cen = req_wr ? ~req_be : '0;
    sram_wr    = req_wr;
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
  end

  always_comb begin
    gnt_nxt    = '0;
    rvalid_nxt = '0;
    if (accept) gnt_nxt[req_ch]     = 1'b1;
    if (pop)    rvalid_nxt[pop_tag] = 1'b1;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      req_ch    <= '0;
      req_wr    <= 1'b0;
      req_be    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      ch_gnt    <= '0;
      ch_rvalid <= '0;
      ch_rdata  <= '0;
      err_o     <= 1'b0;
      credits   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (latch) begin
        req_ch    <= win;
        req_wr    <= ch_wr[win];
        req_be    <= ch_be[win*BE_W +: BE_W];
        req_addr  <= ch_addr[win*ADDR_W +: ADDR_W];
        req_wdata <= ch_wdata[win*DATA_W +: DATA_W];
      end

      ch_gnt    <= gnt_nxt;
      ch_rvalid <= rvalid_nxt;
      if (pop) ch_rdata <= sram_rdata;
      if (sram_rrdy && (fifo_cnt == '0)) err_o <= 1'b1;

      // Credits count reads from latch to data return, so a read sitting in
      // the request stage already holds its slot.
      case ({cr_inc, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Tag storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge aclk) begin
    if (push) tag_mem[wr_ptr] <= req_ch;
  end

`ifndef FAIRY_ARB_FIXED_PRIO_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)   rr_ptr <= '0;
    else if (accept) rr_ptr <= (req_ch == LAST_CH) ? '0 : req_ch + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fairy_sram_arbiter.sv
module tb_fairy_sram_arbiter;

  localparam int NUM_CH      = 2;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int OUTSTANDING = 4;
  localparam int BE_W        = DATA_W / 8;

  logic                       aclk = 1'b0;
  logic                       areset_n = 1'b0;
  logic [NUM_CH-1:0]          ch_req = '0;
  logic [NUM_CH-1:0]          ch_wr = '0;
  logic [NUM_CH*BE_W-1:0]     ch_be = '0;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr = '0;
  logic [NUM_CH*DATA_W-1:0]   ch_wdata = '0;
  logic [NUM_CH-1:0]          ch_gnt;
  logic [NUM_CH-1:0]          ch_rvalid;
  logic [DATA_W-1:0]          ch_rdata;
  logic [BE_W-1:0]            sram_cen;
  logic                       sram_wr;
  logic [ADDR_W-1:0]          sram_addr;
  logic [DATA_W-1:0]          sram_wdata;
  logic                       sram_ack = 1'b0;
  logic                       sram_rrdy = 1'b0;
  logic [DATA_W-1:0]          sram_rdata = '0;
  logic                       err_o;

  always #5 aclk = ~aclk;

  fairy_sram_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_be(ch_be), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .sram_cen(sram_cen), .sram_wr(sram_wr), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ack(sram_ack), .sram_rrdy(sram_rrdy), .sram_rdata(sram_rdata),
    .err_o(err_o)
  );

  typedef struct {
    int                ch;
    logic              wr;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } rv_t;

  // Reference model: channel request queues, a behavioural SRAM with
  // in-order read return, and the expected per-channel read returns.
  req_t              pend[$];
  req_t              cur[NUM_CH];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ret_q[$];
  rv_t               rv_exp[$];
  rv_t               rv_log[$];
  int                gnt_log[$];
  req_t              last_acc;
  logic [DATA_W-1:0] last_acc_data;
  bit                acc_pending;
  bit                auto_on;
  bit                rrdy_once;
  int                ack_pct;
  int                rr_pct;
  logic [DATA_W-1:0] last_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [BE_W-1:0] CEN_IDLE = {BE_W{1'b1}};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  task automatic add_req(input int ch, input logic wr, input logic [BE_W-1:0] be,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    req_t r;
    r.ch = ch; r.wr = wr; r.be = be; r.addr = addr; r.wdata = wdata;
    pend.push_back(r);
  endtask

  // One clock: note what the SRAM accepts at this edge, observe outputs 1ns
  // after the edge, update requesters, then drive the SRAM side for the next edge.
  task automatic step();
    bit   acc;
    req_t pres;
    rv_t  r, e;
    logic [BE_W-1:0] be_e;
    acc        = sram_ack && (sram_cen != CEN_IDLE);
    pres.ch    = -1;
    pres.wr    = sram_wr;
    pres.be    = ~sram_cen;
    pres.addr  = sram_addr;
    pres.wdata = sram_wdata;
    @(posedge aclk);
    #1;
    if (acc) begin
      last_acc    = pres;
      acc_pending = 1'b1;
      if (pres.wr) begin
        logic [DATA_W-1:0] w;
        w = mem_rd(pres.addr);
        for (int b = 0; b < BE_W; b++)
          if (pres.be[b]) w[b*8 +: 8] = pres.wdata[b*8 +: 8];
        mem[pres.addr] = w;
      end else begin
        last_acc_data = mem_rd(pres.addr);
        if (auto_on) ret_q.push_back(last_acc_data);
      end
    end

    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_gnt[c]) begin
        gnt_log.push_back(c);
        if (auto_on) begin
          be_e = cur[c].wr ? cur[c].be : {BE_W{1'b1}};
          check("gnt_after_ack", 64'(acc_pending), 64'd1);
          check("gnt_wr", 64'(last_acc.wr), 64'(cur[c].wr));
          check("gnt_addr", 64'(last_acc.addr), 64'(cur[c].addr));
          check("gnt_be", 64'(last_acc.be), 64'(be_e));
          if (cur[c].wr) check("gnt_wdata", 64'(last_acc.wdata), 64'(cur[c].wdata));
          else begin
            r.ch = c; r.data = last_acc_data;
            rv_exp.push_back(r);
          end
        end
        acc_pending = 1'b0;
      end
    end

    if (ch_rvalid != '0) begin
      r.ch = -1;
      for (int c = 0; c < NUM_CH; c++) if (ch_rvalid[c]) r.ch = c;
      r.data = ch_rdata;
      rv_log.push_back(r);
      if (auto_on) begin
        check("rvalid_onehot", 64'($countones(ch_rvalid)), 64'd1);
        if (rv_exp.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
        else begin
          e = rv_exp.pop_front();
          check("rvalid_ch", 64'(r.ch), 64'(e.ch));
          check("rvalid_data", 64'(ch_rdata), 64'(e.data));
          last_rdata = e.data;
        end
      end
    end else if (auto_on) begin
      check("rdata_hold", 64'(ch_rdata), 64'(last_rdata));
    end

    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_gnt[c]) ch_req[c] = 1'b0;
      if (!ch_req[c]) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].ch == c) begin
            cur[c] = pend[k];
            pend.delete(k);
            ch_req[c]                     = 1'b1;
            ch_wr[c]                      = cur[c].wr;
            ch_be[c*BE_W +: BE_W]         = cur[c].be;
            ch_addr[c*ADDR_W +: ADDR_W]   = cur[c].addr;
            ch_wdata[c*DATA_W +: DATA_W]  = cur[c].wdata;
            break;
          end
        end
      end
    end

    if (auto_on) begin
      sram_ack  = (sram_cen != CEN_IDLE) && ($urandom_range(0, 99) < ack_pct);
      sram_rrdy = 1'b0;
      if (ret_q.size() > 0 && (rrdy_once || $urandom_range(0, 99) < rr_pct)) begin
        sram_rrdy  = 1'b1;
        sram_rdata = ret_q.pop_front();
        rrdy_once  = 1'b0;
      end else begin
        sram_rdata = DATA_W'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    ch_req = '0; ch_wr = '0; ch_be = '0; ch_addr = '0; ch_wdata = '0;
    sram_ack = 1'b0; sram_rrdy = 1'b0; sram_rdata = '0;
    pend.delete(); ret_q.delete(); rv_exp.delete(); rv_log.delete(); gnt_log.delete();
    acc_pending = 1'b0; auto_on = 1'b0; rrdy_once = 1'b0; last_rdata = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pre);
    check({pre, "_cen"},    64'(sram_cen),   64'(CEN_IDLE));
    check({pre, "_wr"},     64'(sram_wr),    64'd0);
    check({pre, "_addr"},   64'(sram_addr),  64'd0);
    check({pre, "_wdata"},  64'(sram_wdata), 64'd0);
    check({pre, "_gnt"},    64'(ch_gnt),     64'd0);
    check({pre, "_rvalid"}, 64'(ch_rvalid),  64'd0);
    check({pre, "_rdata"},  64'(ch_rdata),   64'd0);
    check({pre, "_err"},    64'(err_o),      64'd0);
  endtask

  task automatic run_until_gnt(input int n, input int bound, input string tag);
    int k = 0;
    while (gnt_log.size() < n && k < bound) begin
      step();
      k++;
    end
    check(tag, 64'(gnt_log.size() >= n), 64'd1);
  endtask

  task automatic drain(input int bound, input string tag);
    int k = 0;
    ack_pct = 100;
    rr_pct  = 100;
    while ((pend.size() > 0 || ch_req != '0 || ret_q.size() > 0 || rv_exp.size() > 0 ||
            acc_pending || sram_rrdy) && k < bound) begin
      step();
      k++;
    end
    check(tag, 64'(k < bound), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[6];
`ifdef FAIRY_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif

    // Reset values, both during and right after reset
    #2;
    check_reset_outputs("rst_in");
    do_reset();
    check_reset_outputs("rst_out");

    // Single read, hand-driven SRAM
    add_req(0, 1'b0, '1, 32'h100, '0);
    step();
    step();
    check("t1_cen", 64'(sram_cen), 64'd0);
    check("t1_addr", 64'(sram_addr), 64'h100);
    check("t1_wr", 64'(sram_wr), 64'd0);
    step();
    sram_ack = 1'b1;
    step();
    sram_ack = 1'b0;
    check("t1_gnt", 64'(ch_gnt), 64'd1);
    check("t1_cen_idle", 64'(sram_cen), 64'(CEN_IDLE));
    step();
    check("t1_gnt_pulse", 64'(ch_gnt), 64'd0);
    step();
    step();
    sram_rrdy = 1'b1;
    sram_rdata = 32'hDEADBEEF;
    step();
    sram_rrdy = 1'b0;
    sram_rdata = '0;
    check("t1_rvalid", 64'(ch_rvalid), 64'd1);
    check("t1_rdata", 64'(ch_rdata), 64'hDEADBEEF);
    step();
    check("t1_rvalid_pulse", 64'(ch_rvalid), 64'd0);
    check("t1_rdata_hold", 64'(ch_rdata), 64'hDEADBEEF);
    check("t1_err", 64'(err_o), 64'd0);
    check("t1_gnt_count", 64'(gnt_log.size()), 64'd1);

    // Arbitration order with both channels continuously requesting
    do_reset();
    auto_on = 1'b1; ack_pct = 100; rr_pct = 100;
    for (int i = 0; i < 3; i++) begin
      add_req(0, 1'b0, '1, ADDR_W'(32'h200 + i*8), '0);
      add_req(1, 1'b0, '1, ADDR_W'(32'h204 + i*8), '0);
    end
    run_until_gnt(6, 60, "t2_gnt_timeout");
    for (int i = 0; i < 6; i++) check($sformatf("t2_order%0d", i), 64'(gnt_log[i]), 64'(exp_order[i]));
    drain(200, "t2_drain");
    check("t2_rv_count", 64'(rv_log.size()), 64'd6);

    // Credit stall, then a write while credits are exhausted
    do_reset();
    auto_on = 1'b1; ack_pct = 100; rr_pct = 0;
    for (int i = 0; i < 5; i++) add_req(1, 1'b0, '1, ADDR_W'(32'h500 + i*4), '0);
    run_until_gnt(4, 60, "t3_gnt4_timeout");
    repeat (10) step();
    check("t3_stall_gnts", 64'(gnt_log.size()), 64'd4);
    check("t3_stall_req", 64'(ch_req[1]), 64'd1);
    check("t3_stall_cen", 64'(sram_cen), 64'(CEN_IDLE));
    ack_pct = 0;
    add_req(0, 1'b1, 4'b0011, 32'h300, 32'h12345678);
    repeat (4) step();
    check("t3_wr_cen", 64'(sram_cen), 64'b1100);
    check("t3_wr_wr", 64'(sram_wr), 64'd1);
    check("t3_wr_addr", 64'(sram_addr), 64'h300);
    check("t3_wr_data", 64'(sram_wdata), 64'h12345678);
    ack_pct = 100;
    run_until_gnt(5, 20, "t3_wr_gnt_timeout");
    check("t3_wr_gnt_ch", 64'(gnt_log[4]), 64'd0);
    rrdy_once = 1'b1;
    run_until_gnt(6, 20, "t3_gnt5_timeout");
    check("t3_fifth_ch", 64'(gnt_log[5]), 64'd1);
    drain(200, "t3_drain");
    check("t3_rv_count", 64'(rv_log.size()), 64'd5);

    // In-order return to two channels, then a spurious rrdy
    do_reset();
    mem[32'h400] = 32'h11;
    mem[32'h404] = 32'h22;
    auto_on = 1'b1;
    add_req(0, 1'b0, '1, 32'h400, '0);
    add_req(1, 1'b0, '1, 32'h404, '0);
    drain(100, "t4_drain");
    check("t4_rv_count", 64'(rv_log.size()), 64'd2);
    check("t4_rv0_ch", 64'(rv_log[0].ch), 64'd0);
    check("t4_rv0_data", 64'(rv_log[0].data), 64'h11);
    check("t4_rv1_ch", 64'(rv_log[1].ch), 64'd1);
    check("t4_rv1_data", 64'(rv_log[1].data), 64'h22);
    check("t4_err_pre", 64'(err_o), 64'd0);
    auto_on = 1'b0;
    sram_ack = 1'b0;
    sram_rrdy = 1'b1;
    step();
    sram_rrdy = 1'b0;
    check("t4_err_set", 64'(err_o), 64'd1);
    check("t4_no_rvalid", 64'(ch_rvalid), 64'd0);
    repeat (5) step();
    check("t4_err_sticky", 64'(err_o), 64'd1);

    // Asynchronous reset while ISSUE with two reads outstanding
    do_reset();
    auto_on = 1'b1; ack_pct = 100; rr_pct = 0;
    add_req(0, 1'b0, '1, 32'h600, '0);
    add_req(1, 1'b0, '1, 32'h604, '0);
    add_req(0, 1'b0, '1, 32'h608, '0);
    run_until_gnt(2, 40, "t5_gnt_timeout");
    ack_pct = 0;
    repeat (2) step();
    check("t5_in_issue", 64'(sram_cen), 64'd0);
    #2;
    areset_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    do_reset();
    sram_rrdy = 1'b1;
    step();
    sram_rrdy = 1'b0;
    check("t5_err_after_reset", 64'(err_o), 64'd1);

    // Randomized traffic against the model
    do_reset();
    auto_on = 1'b1;
    for (int i = 0; i < 800; i++) begin
      ack_pct = (i % 200 < 100) ? 60 : 90;
      rr_pct  = (i % 150 < 75) ? 20 : 70;
      if (pend.size() < 6 && $urandom_range(0, 2) == 0)
        add_req(int'($urandom_range(0, NUM_CH-1)), 1'($urandom_range(0, 1)),
                BE_W'($urandom_range(1, (1 << BE_W) - 1)),
                ADDR_W'($urandom_range(0, 15) * 4), DATA_W'($urandom));
      step();
    end
    drain(2000, "rand_drain");
    check("rand_rv_exp_empty", 64'(rv_exp.size()), 64'd0);
    check("rand_err", 64'(err_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
